// File: rtl/posit_encode_arbiter.sv
// posit_encode_arbiter: round-robin front end that shares one combinational
// posit encoder among N_REQ requesters through a two-stage valid/ready pipe.
// Results come back in acceptance order, each tagged with its requester index.

// format_encoder: packs decoded posit fields into a WIDTH-bit posit.
// Body bits after the sign are: regime run, EN exponent bits, then the
// mantissa MSB-first. Bits past the end of the word are truncated (no rounding).
// n_r negates the result (two's complement of the whole word).
module format_encoder #(
    parameter int WIDTH = 7,
    parameter int EN    = 1,
    parameter int W_REG = 4,
    parameter int W_EXP = 4,
    parameter int W_MAN = 7
) (
    input  logic signed [W_REG-1:0] regime,
    input  logic signed [W_EXP-1:0] exponent,
    input  logic [W_MAN-1:0]        mantissa,
    input  logic                    n_r,
    output logic [WIDTH-1:0]        posit
);
    localparam int BW = WIDTH - 1;    // body bits below the sign
    localparam int TW = EN + W_MAN;   // exponent + mantissa tail

    logic signed [W_REG+1:0] k;
    logic [W_REG+1:0]        run_len;   // identical regime bits
    logic [W_REG+1:0]        reg_len;   // run plus terminating bit
    logic [BW-1:0]           reg_bits;
    logic [TW+BW-1:0]        tail_ext;
    logic [TW+BW-1:0]        tail_sh;
    logic [BW-1:0]           body;
    logic                    unused_exp_hi;

    // Only the low EN exponent bits are encodable; upper bits are ignored.
    assign unused_exp_hi = ^exponent;

    assign k       = {{2{regime[W_REG-1]}}, regime};
    // k >= 0 : k+1 ones then a zero; k < 0 : -k zeros then a one
    assign run_len = k[W_REG+1] ? (-k) : (k + (W_REG+2)'(1));
    assign reg_len = run_len + (W_REG+2)'(1);

    assign reg_bits = k[W_REG+1] ? ({1'b1, {(BW-1){1'b0}}} >> run_len)
                                 : ~({BW{1'b1}} >> run_len);

    // Tail is placed right after the regime, then truncated to BW bits.
    assign tail_ext = {exponent[EN-1:0], mantissa, {BW{1'b0}}};
    assign tail_sh  = tail_ext >> reg_len;
    assign body     = reg_bits | tail_sh[TW+BW-1 -: BW];

    assign posit = n_r ? (-{1'b0, body}) : {1'b0, body};
endmodule

module posit_encode_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 7,
    parameter int EN    = 1,
    parameter int W_REG = $clog2(WIDTH) + 1,
    parameter int W_EXP = $clog2(WIDTH) + 1,
    parameter int W_MAN = WIDTH,
    parameter int TAG_W = (N_REQ > 1 ? $clog2(N_REQ) : 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*W_REG-1:0]   req_regime,
    input  logic [N_REQ*W_EXP-1:0]   req_exponent,
    input  logic [N_REQ*W_MAN-1:0]   req_mantissa,
    input  logic [N_REQ-1:0]         req_n_r,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_posit,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy,
    output logic [1:0]               in_flight
);
    logic s1_valid, s2_valid, s1_ready, s2_ready;
    logic [TAG_W-1:0] ptr, grant_idx, s1_tag, s2_tag;
    logic [TAG_W:0]   cand;
    logic             grant_any;
    logic [N_REQ-1:0] grant;

    logic signed [W_REG-1:0] s1_regime;
    logic signed [W_EXP-1:0] s1_exponent;
    logic [W_MAN-1:0]        s1_mantissa;
    logic                    s1_n_r;
    logic [WIDTH-1:0]        enc_posit, s2_posit;

    logic [W_REG-1:0] regime_arr   [N_REQ];
    logic [W_EXP-1:0] exponent_arr [N_REQ];
    logic [W_MAN-1:0] mantissa_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign regime_arr[i]   = req_regime[i*W_REG +: W_REG];
        assign exponent_arr[i] = req_exponent[i*W_EXP +: W_EXP];
        assign mantissa_arr[i] = req_mantissa[i*W_MAN +: W_MAN];
    end

    // Ready chain: a stage can take data if empty or if it drains this cycle.
    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = {1'b0, ptr} + (TAG_W+1)'(off);
            if (cand >= (TAG_W+1)'(N_REQ))
                cand = cand - (TAG_W+1)'(N_REQ);
            if (!grant_any && req_valid[cand[TAG_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[TAG_W-1:0];
            end
        end
        if (grant_any)
            grant[grant_idx] = 1'b1;
    end

    assign req_ready = (rst || !s1_ready) ? '0 : grant;

    format_encoder #(
        .WIDTH(WIDTH), .EN(EN), .W_REG(W_REG), .W_EXP(W_EXP), .W_MAN(W_MAN)
    ) u_enc (
        .regime   (s1_regime),
        .exponent (s1_exponent),
        .mantissa (s1_mantissa),
        .n_r      (s1_n_r),
        .posit    (enc_posit)
    );

    // Pipeline advance, S1 load from the granted requester, pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            ptr         <= '0;
            s1_tag      <= '0;
            s1_regime   <= '0;
            s1_exponent <= '0;
            s1_mantissa <= '0;
            s1_n_r      <= 1'b0;
            s2_posit    <= '0;
            s2_tag      <= '0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_posit <= enc_posit;
                    s2_tag   <= s1_tag;
                end
            end
            if (s1_ready) begin
                s1_valid <= grant_any;
                if (grant_any) begin
                    s1_tag      <= grant_idx;
                    s1_regime   <= regime_arr[grant_idx];
                    s1_exponent <= exponent_arr[grant_idx];
                    s1_mantissa <= mantissa_arr[grant_idx];
                    s1_n_r      <= req_n_r[grant_idx];
                    ptr <= (grant_idx == TAG_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_posit = s2_posit;
    assign out_tag   = s2_tag;
    assign in_flight = {1'b0, s1_valid} + {1'b0, s2_valid};
    assign busy      = |in_flight;
endmodule

// File: tb/tb_posit_encode_arbiter.sv
// Bench for posit_encode_arbiter: constant vector table, hand sequences for
// arbitration/backpressure/reset, and a random phase against a reference model.
module tb_posit_encode_arbiter;
    localparam int N     = 4;
    localparam int WIDTH = 7;
    localparam int EN    = 1;
    localparam int W_REG = 4;
    localparam int W_EXP = 4;
    localparam int W_MAN = 7;
    localparam int TAG_W = 2;

    logic clk, rst;
    logic [N-1:0]       req_valid, req_ready, req_n_r;
    logic [N*W_REG-1:0] req_regime;
    logic [N*W_EXP-1:0] req_exponent;
    logic [N*W_MAN-1:0] req_mantissa;
    logic               out_valid, out_ready, busy;
    logic [WIDTH-1:0]   out_posit;
    logic [TAG_W-1:0]   out_tag;
    logic [1:0]         in_flight;

    posit_encode_arbiter #(
        .N_REQ(N), .WIDTH(WIDTH), .EN(EN), .W_REG(W_REG), .W_EXP(W_EXP),
        .W_MAN(W_MAN), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_regime(req_regime), .req_exponent(req_exponent),
        .req_mantissa(req_mantissa), .req_n_r(req_n_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit),
        .out_tag(out_tag), .busy(busy), .in_flight(in_flight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built as one bit stream: regime, exponent, mantissa.
    function automatic logic [WIDTH-1:0] ref_posit(int k, int e, int m, bit neg);
        longint regv, stream, body, val;
        int rl, total, bw, tw;
        bw = WIDTH - 1;
        tw = EN + W_MAN;
        if (k >= 0) begin
            rl   = k + 2;
            regv = ((longint'(1) << (k + 1)) - 1) << 1;
        end else begin
            rl   = 1 - k;
            regv = 1;
        end
        stream = (regv << tw) | ((longint'(e) & ((longint'(1) << EN) - 1)) << W_MAN)
               | (longint'(m) & ((longint'(1) << W_MAN) - 1));
        total = rl + tw;
        body  = (total >= bw) ? (stream >> (total - bw)) : (stream << (bw - total));
        body  = body & ((longint'(1) << bw) - 1);
        val   = neg ? ((longint'(1) << WIDTH) - body) : body;
        return WIDTH'(val);
    endfunction

    function automatic int idx_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Scoreboard: queue of accepted results, oldest first; m_s2 says the
    // oldest one has reached the output register.
    typedef struct { logic [WIDTH-1:0] posit; int tag; } exp_t;
    exp_t q[$];
    bit   m_s2 = 1'b0;
    int   mptr = 0;
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        int g, exp_rdy, idx;
        bit s1_full, s2r, s1r, pop;
        exp_t e;
        if (mon_en) begin
            if (rst) begin
                chk("ready_in_reset", req_ready, 0);
                q.delete();
                m_s2 = 1'b0;
                mptr = 0;
            end else begin
                s1_full = (q.size() - int'(m_s2)) == 1;
                chk("in_flight", in_flight, q.size());
                chk("busy", busy, q.size() != 0);
                chk("out_valid", out_valid, m_s2);
                if (m_s2) begin
                    chk("out_posit", out_posit, q[0].posit);
                    chk("out_tag", out_tag, q[0].tag);
                end
                s2r = !m_s2 || out_ready;
                s1r = !s1_full || s2r;
                g = -1;
                for (int off = 0; off < N; off++) begin
                    idx = (mptr + off) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                exp_rdy = (s1r && g >= 0) ? (1 << g) : 0;
                chk("req_ready", req_ready, exp_rdy);
                pop = m_s2 && out_ready;
                if (pop) void'(q.pop_front());
                if (s1_full && s2r) m_s2 = 1'b1;
                else if (pop) m_s2 = 1'b0;
                if (s1r && g >= 0) begin
                    e.posit = ref_posit(int'($signed(req_regime[g*W_REG +: W_REG])),
                                        int'(req_exponent[g*W_EXP +: W_EXP]),
                                        int'(req_mantissa[g*W_MAN +: W_MAN]),
                                        req_n_r[g]);
                    e.tag = g;
                    q.push_back(e);
                    mptr = (g + 1) % N;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int i, bit v, int k, int e, int m, bit nr);
        req_valid[i] = v;
        req_regime[i*W_REG +: W_REG]   = W_REG'(k);
        req_exponent[i*W_EXP +: W_EXP] = W_EXP'(e);
        req_mantissa[i*W_MAN +: W_MAN] = W_MAN'(m);
        req_n_r[i] = nr;
    endtask

    task automatic rand_ops();
        req_regime   = (N*W_REG)'($urandom);
        req_exponent = (N*W_EXP)'($urandom);
        req_mantissa = {(N*W_MAN)'($urandom)};
        req_n_r      = N'($urandom);
    endtask

    typedef struct { int r; int k; int e; int m; bit nr; logic [WIDTH-1:0] posit; } vec_t;
    vec_t vecs[9];

    int exp_order[8];
    logic [WIDTH-1:0] snap_posit;
    logic [TAG_W-1:0] snap_tag;

    initial begin
        vecs[0] = '{2,  0, 0, 'h00, 1'b0, 7'h20};
        vecs[1] = '{2,  0, 0, 'h00, 1'b1, 7'h60};
        vecs[2] = '{0,  1, 0, 'h00, 1'b0, 7'h30};
        vecs[3] = '{1, -1, 0, 'h00, 1'b0, 7'h10};
        vecs[4] = '{3,  0, 1, 'h40, 1'b0, 7'h2C};
        vecs[5] = '{3,  0, 1, 'h40, 1'b1, 7'h54};
        vecs[6] = '{1,  2, 1, 'h7F, 1'b0, 7'h3B};
        vecs[7] = '{0, -2, 0, 'h7F, 1'b0, 7'h0B};
        vecs[8] = '{2,  7, 0, 'h00, 1'b0, 7'h3F};
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst = 1'b1; out_ready = 1'b1;
        req_valid = '0; req_regime = '0; req_exponent = '0; req_mantissa = '0; req_n_r = '0;
        mon_en = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_posit", out_posit, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_flight", in_flight, 0);
        tick();
        rst = 1'b0;

        // Single requests: two-cycle latency and constant expected encodings
        foreach (vecs[j]) begin
            tick();
            drive(vecs[j].r, 1'b1, vecs[j].k, vecs[j].e, vecs[j].m, vecs[j].nr);
            @(negedge clk);
            chk("vec_accept", req_ready[vecs[j].r], 1);
            tick();
            req_valid = '0;
            @(negedge clk);
            chk("vec_lat1_valid", out_valid, 0);
            tick();
            @(negedge clk);
            chk("vec_lat2_valid", out_valid, 1);
            chk("vec_posit", out_posit, vecs[j].posit);
            chk("vec_tag", out_tag, vecs[j].r);
        end
        tick(); tick();

        // Round robin from ptr=0 with everyone valid
        rst = 1'b1; tick(); rst = 1'b0;
        rand_ops(); req_valid = '1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j < 8) chk("rr_grant", idx_of(req_ready), exp_order[j]);
            if (j >= 2) begin
                chk("rr_out_valid", out_valid, 1);
                chk("rr_out_tag", out_tag, exp_order[j-2]);
            end
            tick();
            rand_ops();
            if (j == 7) req_valid = '0;
        end
        tick(); tick();

        // Wrap and skip: ptr -> 2 via requester 1, then only 3 and 1 valid
        rand_ops(); req_valid = 4'b0010;
        tick(); req_valid = 4'b1010;
        @(negedge clk); chk("wrap_grant3", idx_of(req_ready), 3);
        tick();
        @(negedge clk); chk("wrap_grant1", idx_of(req_ready), 1);
        tick();
        @(negedge clk); chk("wrap_grant3b", idx_of(req_ready), 3);
        tick(); req_valid = '0;
        tick(); tick();

        // Drop without grant: fill pipe from 2, then 3 waits and withdraws
        out_ready = 1'b0; req_valid = 4'b0100;
        tick(); tick();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("drop_in_flight", in_flight, 2);
        chk("drop_ready", req_ready, 0);
        tick();
        @(negedge clk); chk("drop_ready2", req_ready, 0);
        tick(); req_valid = '0; out_ready = 1'b1;
        tick(); tick(); tick();
        req_valid = '1;
        @(negedge clk); chk("drop_ptr_kept", idx_of(req_ready), 3);
        tick(); req_valid = '0;
        tick(); tick(); tick();

        // Backpressure: stream from requester 1 while output is stalled
        out_ready = 1'b0; req_valid = 4'b0010;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                chk("bp_in_flight", in_flight, 2);
                chk("bp_ready", req_ready, 0);
            end
            if (j == 2) begin snap_posit = out_posit; snap_tag = out_tag; end
            if (j > 2) begin
                chk("bp_posit_stable", out_posit, snap_posit);
                chk("bp_tag_stable", out_tag, snap_tag);
            end
            tick();
            rand_ops();
        end
        out_ready = 1'b1;
        tick(); tick(); tick();
        req_valid = '0;
        tick(); tick(); tick();

        // Reset with two entries in flight
        out_ready = 1'b0; req_valid = 4'b0001;
        tick(); tick();
        req_valid = '0;
        @(negedge clk); chk("mid_in_flight", in_flight, 2);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_in_flight0", in_flight, 0);
        tick(); tick();
        req_valid = '1;
        @(negedge clk); chk("mid_first_grant", idx_of(req_ready), 0);
        tick(); req_valid = '0;
        tick(); tick(); tick();

        // Random traffic against the scoreboard
        for (int j = 0; j < 500; j++) begin
            rand_ops();
            req_valid = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; req_valid = '0; out_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("final_idle", in_flight, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
